vc_input_buffer: RTL and testbench
==================================

// Module: vc_input_buffer
// PURPOSE
//  Input stage of one ring-router port. Holds one packet per virtual channel (VC0 even, VC1 odd).
//  Decodes each held packet into a forward or eject request. These requests drive the req0/req1
//  inputs of the downstream 2-way rotating prioritizers (forward-output arbiter, local-eject arbiter).
//  Frees a slot when the matching grant returns. Even/odd polarity keeps link writes and internal reads on opposite VCs.
// PARAMETERS
//  DATA_WIDTH  64  packet width
//  VC_BIT      63  bit index of the VC field (0 = even VC, 1 = odd VC)
//  HOP_LSB     48  LSB of hop-count field
//  HOP_W       8   hop-count width; field is [HOP_LSB+HOP_W-1:HOP_LSB]
// PORTS
//  clk        in   1           clock, rising edge
//  reset      in   1           synchronous, active-high
//  polarity   in   1           toggles every cycle; common to whole router
//  in_si      in   1           upstream link valid
//  in_ri      out  1           ready to upstream link
//  in_di      in   DATA_WIDTH  upstream link data
//  req_fwd    out  1           forward request -> forward arbiter
//  req_local  out  1           eject request -> local arbiter
//  gnt_fwd    in   1           grant from forward arbiter
//  gnt_local  in   1           grant from local arbiter
//  dout       out  DATA_WIDTH  packet presented to arbiters, hop field already updated
//  vc_full    out  2           occupancy flag per VC buffer, bit v = VC v
// BEHAVIOUR
//  Storage: buf[0], buf[1] (DATA_WIDTH each), full[1:0]. Reset: full=00, buffer contents don't-care.
//  Link side: only the VC equal to polarity is active (ext VC = polarity).
//   - in_ri = ~full[polarity]. This is 1 in the first cycle after reset.
//   - Accept when in_si & in_ri & (in_di[VC_BIT]==polarity): buf[polarity]<=in_di, full[polarity]<=1.
//   - in_si with VC bit != polarity: protocol violation. Ignore it; no state change.
//  Internal side: only the VC equal to ~polarity is active (int VC = ~polarity). h = hop field of buf[~polarity].
//   - req_fwd   = full[~polarity] & (h != 0)
//   - req_local = full[~polarity] & (h == 0)
//   - Both requests are combinational from registered state, mutually exclusive, and 0 after reset.
//   - dout = buf[~polarity] with hop field = h-1 when h!=0; dout is unchanged when h==0.
//   - Release: (req_fwd&gnt_fwd) | (req_local&gnt_local) -> full[~polarity]<=0 at next edge.
//   - A grant without its matching request is ignored. A held request with no grant keeps the packet and
//     retries on the next cycle of the same polarity.
//  Accept and release never target the same VC in one cycle, so no read/write collision is possible.
//  Latency: accepted at edge N -> request asserted cycle N+1 -> with immediate grant the slot is free
//   from edge N+2, when the link side may refill it. This gives 1 packet / 2 cycles per VC, 1 / cycle per port.
//  Hop arithmetic: HOP_W-bit unsigned decrement, never applied at 0, so no wrap.
//  vc_full = full. Polarity is never gated by this block.
//  Reset mid-operation: all held packets are dropped. full=00 and both requests deassert from the next cycle.
// TESTING
//  T1 reset: assert reset 2 cycles -> vc_full=00, req_fwd=req_local=0, in_ri=1.
//  T2 forward: pol=0, in_si=1, di VC=0, hop=3, data=0xA5 -> next cycle req_fwd=1, dout hop=2, data=0xA5;
//     gnt_fwd=1 -> vc_full[0]=0 next cycle.
//  T3 eject: pol=1, VC=1, hop=0 -> next cycle req_local=1, req_fwd=0, dout==di; gnt_local=0 for 4 cycles
//     -> req_local pulses on each pol=0 cycle; in_ri=0 on pol=1 cycles.
//  T4 wrong-VC: pol=0, in_si=1, di VC=1 -> no accept, vc_full stays 00.
//  T5 back-to-back: packets on both VCs every cycle, grants always 1 -> one request per cycle,
//     alternating VC0/VC1, no loss over 100 packets.
//  T6 reset mid-op: both VCs full, reset=1 for 1 cycle -> vc_full=00, no request on the following cycles.

Source files
------------

// File: rtl/vc_input_buffer.sv
// Two-VC ring-router input stage: one packet per VC, decoded into forward/eject requests; accept->request 1 cycle, slot free 2 cycles after accept with immediate grant.
// Backpressure: in_ri drops while the link-side VC slot is occupied; an ungranted request holds its packet and retries on the next cycle of the same polarity.
module vc_input_buffer #(
  parameter int DATA_WIDTH = 64,
  parameter int VC_BIT     = 63,
  parameter int HOP_LSB    = 48,
  parameter int HOP_W      = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  polarity,
  input  logic                  in_si,
  output logic                  in_ri,
  input  logic [DATA_WIDTH-1:0] in_di,
  output logic                  req_fwd,
  output logic                  req_local,
  input  logic                  gnt_fwd,
  input  logic                  gnt_local,
  output logic [DATA_WIDTH-1:0] dout,
  output logic [1:0]            vc_full
);

  logic [DATA_WIDTH-1:0] vc_buf [2];
  logic [1:0]            full;

  logic                  ext_vc;
  logic                  int_vc;
  logic                  accept;
  logic                  release_slot;
  logic [DATA_WIDTH-1:0] int_pkt;
  logic [HOP_W-1:0]      hop;

  // The link writes the VC matching polarity while the arbiters read the other one.
  assign ext_vc  = polarity;
  assign int_vc  = ~polarity;

  assign in_ri   = ~full[ext_vc];
  assign accept  = in_si & in_ri & (in_di[VC_BIT] == ext_vc);

  assign int_pkt   = vc_buf[int_vc];
  assign hop       = int_pkt[HOP_LSB +: HOP_W];
  assign req_fwd   = full[int_vc] & (hop != '0);
  assign req_local = full[int_vc] & (hop == '0);

  assign release_slot = (req_fwd & gnt_fwd) | (req_local & gnt_local);

  // Hop is decremented only on the forwarded copy; an ejecting packet is passed through untouched.
  always_comb begin
    dout = int_pkt;
    if (hop != '0) begin
      dout[HOP_LSB +: HOP_W] = hop - HOP_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      full <= 2'b00;
    end else begin
      if (accept) begin
        full[ext_vc] <= 1'b1;
      end
      if (release_slot) begin
        full[int_vc] <= 1'b0;
      end
    end
  end

  // Payload storage needs no reset; it is only observed while its full bit is set.
  always_ff @(posedge clk) begin
    if (accept) begin
      vc_buf[ext_vc] <= in_di;
    end
  end

  assign vc_full = full;

endmodule

// File: tb/tb_vc_input_buffer.sv
module tb_vc_input_buffer;

  localparam int DW = 64;

  logic          clk = 1'b0;
  logic          reset;
  logic          polarity;
  logic          in_si;
  logic          in_ri;
  logic [DW-1:0] in_di;
  logic          req_fwd;
  logic          req_local;
  logic          gnt_fwd;
  logic          gnt_local;
  logic [DW-1:0] dout;
  logic [1:0]    vc_full;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  vc_input_buffer #(.DATA_WIDTH(64), .VC_BIT(63), .HOP_LSB(48), .HOP_W(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .polarity  (polarity),
    .in_si     (in_si),
    .in_ri     (in_ri),
    .in_di     (in_di),
    .req_fwd   (req_fwd),
    .req_local (req_local),
    .gnt_fwd   (gnt_fwd),
    .gnt_local (gnt_local),
    .dout      (dout),
    .vc_full   (vc_full)
  );

  function automatic logic [63:0] mk(bit vc, logic [7:0] hop, logic [47:0] d);
    return {vc, 7'b0, hop, d};
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  typedef struct {
    bit          rst, pol, si;
    logic [63:0] di;
    bit          gf, gl;
    bit          chk, chk_dout;
    logic [1:0]  e_full;
    bit          e_ri, e_rf, e_rl;
    logic [63:0] e_dout;
  } vec_t;

  function automatic vec_t v(bit rst, bit pol, bit si, logic [63:0] di, bit gf, bit gl,
                             bit chk, bit cd, logic [1:0] ef, bit eri, bit erf, bit erl,
                             logic [63:0] ed);
    vec_t r;
    r.rst = rst; r.pol = pol; r.si = si; r.di = di; r.gf = gf; r.gl = gl;
    r.chk = chk; r.chk_dout = cd; r.e_full = ef; r.e_ri = eri; r.e_rf = erf; r.e_rl = erl;
    r.e_dout = ed;
    return r;
  endfunction

  // Spec-level model: one slot per VC holding the raw packet as received.
  bit          m_full [2];
  logic [63:0] m_pkt  [2];

  task automatic drive(bit rst, bit pol, bit si, logic [63:0] di, bit gf, bit gl);
    reset = rst; polarity = pol; in_si = si; in_di = di; gnt_fwd = gf; gnt_local = gl;
  endtask

  // Compare DUT against the model, then advance the model by one clock.
  task automatic model_cycle(output bit delivered);
    bit          iv;
    logic [7:0]  h;
    logic [63:0] exp_d;
    bit          e_rf, e_rl, rel, acc;
    iv    = !polarity;
    h     = m_pkt[iv][55:48];
    e_rf  = m_full[iv] && (h != 8'd0);
    e_rl  = m_full[iv] && (h == 8'd0);
    exp_d = m_pkt[iv];
    if (h != 8'd0) exp_d[55:48] = h - 8'd1;
    check("rnd_vc_full", {62'd0, vc_full}, {62'd0, m_full[1], m_full[0]});
    check("rnd_in_ri", {63'd0, in_ri}, {63'd0, !m_full[polarity]});
    check("rnd_req_fwd", {63'd0, req_fwd}, {63'd0, e_rf});
    check("rnd_req_local", {63'd0, req_local}, {63'd0, e_rl});
    if (m_full[iv]) check("rnd_dout", dout, exp_d);
    delivered = (req_fwd && gnt_fwd) || (req_local && gnt_local);
    rel = (e_rf && gnt_fwd) || (e_rl && gnt_local);
    acc = in_si && !m_full[polarity] && (in_di[63] == polarity);
    if (reset) begin
      m_full[0] = 0; m_full[1] = 0;
    end else begin
      if (rel) m_full[iv] = 0;
      if (acc) begin
        m_full[polarity] = 1;
        m_pkt[polarity]  = in_di;
      end
    end
  endtask

  vec_t vt [18];

  initial begin
    logic [63:0] pa, pb, pc, pd, pe;
    bit          dlv;
    int          delivered_cnt;
    pa = mk(0, 8'd3,   48'hA5);
    pb = mk(1, 8'd0,   48'h5A);
    pc = mk(1, 8'd1,   48'h77);
    pd = mk(0, 8'hFF,  48'h99);
    pe = mk(1, 8'd2,   48'h33);
    vt[0]  = v(1,0,0,64'd0,0,0, 0,0, 2'b00,1,0,0,64'd0);
    vt[1]  = v(1,1,0,64'd0,0,0, 1,0, 2'b00,1,0,0,64'd0);
    vt[2]  = v(0,0,1,pa,0,0,    1,0, 2'b00,1,0,0,64'd0);
    vt[3]  = v(0,1,0,64'd0,1,0, 1,1, 2'b01,1,1,0,mk(0,8'd2,48'hA5));
    vt[4]  = v(0,0,0,64'd0,0,0, 1,0, 2'b00,1,0,0,64'd0);
    vt[5]  = v(0,1,1,pb,0,0,    1,0, 2'b00,1,0,0,64'd0);
    vt[6]  = v(0,0,0,64'd0,0,0, 1,1, 2'b10,1,0,1,pb);
    vt[7]  = v(0,1,0,64'd0,0,0, 1,0, 2'b10,0,0,0,64'd0);
    vt[8]  = v(0,0,0,64'd0,0,0, 1,1, 2'b10,1,0,1,pb);
    vt[9]  = v(0,1,0,64'd0,0,0, 1,0, 2'b10,0,0,0,64'd0);
    vt[10] = v(0,0,0,64'd0,1,1, 1,1, 2'b10,1,0,1,pb);
    vt[11] = v(0,1,1,mk(0,8'd0,48'h11),0,0, 1,0, 2'b00,1,0,0,64'd0);
    vt[12] = v(0,0,1,mk(1,8'd7,48'h22),1,0, 1,0, 2'b00,1,0,0,64'd0);
    vt[13] = v(0,1,1,pc,0,0,    1,0, 2'b00,1,0,0,64'd0);
    vt[14] = v(0,0,1,pd,0,1,    1,1, 2'b10,1,1,0,mk(1,8'd0,48'h77));
    vt[15] = v(0,1,1,pe,1,0,    1,1, 2'b11,0,1,0,mk(0,8'hFE,48'h99));
    vt[16] = v(0,0,0,64'd0,1,0, 1,1, 2'b10,1,1,0,mk(1,8'd0,48'h77));
    vt[17] = v(0,1,0,64'd0,0,0, 1,0, 2'b00,1,0,0,64'd0);

    for (int i = 0; i < 18; i++) begin
      drive(vt[i].rst, vt[i].pol, vt[i].si, vt[i].di, vt[i].gf, vt[i].gl);
      @(negedge clk);
      if (vt[i].chk) begin
        check($sformatf("vec%0d_vc_full", i), {62'd0, vc_full}, {62'd0, vt[i].e_full});
        check($sformatf("vec%0d_in_ri", i), {63'd0, in_ri}, {63'd0, vt[i].e_ri});
        check($sformatf("vec%0d_req_fwd", i), {63'd0, req_fwd}, {63'd0, vt[i].e_rf});
        check($sformatf("vec%0d_req_local", i), {63'd0, req_local}, {63'd0, vt[i].e_rl});
        if (vt[i].chk_dout) check($sformatf("vec%0d_dout", i), dout, vt[i].e_dout);
      end
      @(posedge clk); #1;
    end

    m_full[0] = 0; m_full[1] = 0;
    m_pkt[0] = '0; m_pkt[1] = '0;

    // Back-to-back: a packet on the link VC every cycle, grants always on.
    delivered_cnt = 0;
    for (int k = 0; k < 104; k++) begin
      logic [63:0] p;
      p = mk(!polarity, 8'($urandom_range(0, 3)), {16'd0, $urandom});
      drive(0, !polarity, k < 100, p, 1, 1);
      @(negedge clk);
      if (k >= 1 && k <= 100) check("b2b_one_req", {63'd0, req_fwd | req_local}, 64'd1);
      model_cycle(dlv);
      if (dlv) delivered_cnt++;
      @(posedge clk); #1;
    end
    check("b2b_delivered", 64'(delivered_cnt), 64'd100);

    // Random traffic including wrong-VC writes and missing or mismatched grants.
    for (int k = 0; k < 600; k++) begin
      bit          np, vc;
      logic [7:0]  hp;
      np = !polarity;
      vc = ($urandom_range(0, 7) == 0) ? !np : np;
      hp = ($urandom_range(0, 2) == 0) ? 8'd0 : 8'($urandom);
      drive(0, np, $urandom_range(0, 3) != 0, mk(vc, hp, {16'd0, $urandom}),
            1'($urandom), 1'($urandom));
      @(negedge clk);
      model_cycle(dlv);
      @(posedge clk); #1;
    end

    // Reset mid-operation: fill both VCs with no grants, then reset for one cycle.
    for (int k = 0; k < 2; k++) begin
      drive(0, !polarity, 1, mk(!polarity, 8'd4, 48'hBEEF), 0, 0);
      @(negedge clk);
      model_cycle(dlv);
      @(posedge clk); #1;
    end
    drive(1, !polarity, 0, 64'd0, 0, 0);
    @(negedge clk);
    check("rst_mid_both_full", {62'd0, vc_full}, 64'd3);
    model_cycle(dlv);
    @(posedge clk); #1;
    for (int k = 0; k < 3; k++) begin
      drive(0, !polarity, 0, 64'd0, 1, 1);
      @(negedge clk);
      check("rst_mid_vc_full", {62'd0, vc_full}, 64'd0);
      check("rst_mid_no_req", {62'd0, req_fwd, req_local}, 64'd0);
      check("rst_mid_in_ri", {63'd0, in_ri}, 64'd1);
      @(posedge clk); #1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
